// File: rtl/instr_sequencer_pkg.sv
// Purpose : shared encodings for the multi-cycle instruction sequencer.
// Latency : n/a (constants, types and one helper function only).
// Backpressure: n/a.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_LD_WB  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Opcode field [15:12]
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_BCOND = 4'hC;

    // Extension field [7:4] for OP_MEM, and the compare function code
    // shared by R-type ext and the immediate opcode.
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JCOND = 4'hC;
    localparam logic [3:0] CMP       = 4'hB;

    // Condition codes carried in [11:8] for Bcond/Jcond
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;

    // Bit positions inside flags[4:0] = {N,Z,F,L,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    // Logical immediates are zero-extended so masks like 0x0080 stay positive.
    function automatic logic is_zext_imm(input logic [3:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/instr_sequencer_cond_eval.sv
// Purpose : evaluates a branch/jump condition code against the registered ALU flags.
// Latency : combinational.
// Backpressure: none.
// Ports   : cond[3:0] condition code, flags[4:0] {N,Z,F,L,C}, take = condition true.
module cond_eval
    import seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       take
);

    logic n, z, f, c;
    logic unused_flag_l;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign f = flags[FLAG_F];
    assign c = flags[FLAG_C];
    // L is produced by the ALU but no condition in this ISA tests it.
    assign unused_flag_l = flags[FLAG_L];

    always_comb begin
        take = 1'b0;
        unique case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_FS: take = f;
            COND_FC: take = !f;
            COND_GT: take = n;
            COND_LE: take = !n;
            COND_LT: take = !n && !z;
            COND_GE: take = n || z;
            COND_UC: take = 1'b1;
            default: take = 1'b0;  // 1111 and unassigned codes never take
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Purpose : multi-cycle fetch/decode/execute control for the 16-bit register/ALU/memory datapath.
// Latency : ALU, store, branch and jump take 3 cycles; load takes 4; HALT holds until reset.
// Backpressure: none; memory is assumed to return read data exactly one cycle after the address.
// Ports   : mem_rdata/flags/pc in from datapath; alu_op, imm, imm_sel, mux_a_sel, mux_b_sel,
//           reg_en, wb_sel, flag_en, mem_addr_sel, mem_we, pc_en, pc_ld, pc_tgt_sel,
//           pc_target out to datapath; ir and halted for debug/status.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 10,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   mem_rdata,
    input  logic [4:0]      flags,
    input  logic [PC_W-1:0] pc,
    output logic [7:0]      alu_op,
    output logic [DW-1:0]   imm,
    output logic            imm_sel,
    output logic [3:0]      mux_a_sel,
    output logic [3:0]      mux_b_sel,
    output logic [15:0]     reg_en,
    output logic            wb_sel,
    output logic            flag_en,
    output logic            mem_addr_sel,
    output logic            mem_we,
    output logic            pc_en,
    output logic            pc_ld,
    output logic            pc_tgt_sel,
    output logic [PC_W-1:0] pc_target,
    output logic [DW-1:0]   ir,
    output logic            halted
);

    state_t        state;
    logic [DW-1:0] ir_q;

    logic [3:0]      op, rd, ext, rs;
    logic            is_mem, is_branch, is_cmp, take;
    logic [15:0]     rd_onehot;
    logic [PC_W-1:0] disp_ext;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign ext = ir_q[7:4];
    assign rs  = ir_q[3:0];

    assign is_mem    = (op == OP_MEM);
    assign is_branch = (op == OP_BCOND);
    assign is_cmp    = ((op == OP_RTYPE) && (ext == CMP)) || (op == CMP);
    assign rd_onehot = 16'h0001 << rd;
    assign disp_ext  = PC_W'($signed(ir_q[7:0]));

    cond_eval u_cond_eval (
        .cond  (rd),
        .flags (flags),
        .take  (take)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            ir_q  <= '0;
        end else begin
            unique case (state)
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    ir_q  <= mem_rdata;
                    state <= (mem_rdata == HALT_WORD) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC:   state <= (is_mem && ext == EXT_LOAD) ? ST_LD_WB : ST_FETCH;
                ST_LD_WB:  state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Controls decode from the registered state and IR. Reset forces every
    // output low in the same cycle so an interrupted store/writeback cannot
    // leak a write while reset is held.
    always_comb begin
        alu_op       = '0;
        imm          = '0;
        imm_sel      = 1'b0;
        mux_a_sel    = '0;
        mux_b_sel    = '0;
        reg_en       = '0;
        wb_sel       = 1'b0;
        flag_en      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        pc_en        = 1'b0;
        pc_ld        = 1'b0;
        pc_tgt_sel   = 1'b0;
        pc_target    = '0;
        ir           = '0;
        halted       = 1'b0;
        if (!reset) begin
            alu_op    = {op, ext};
            imm       = is_zext_imm(op) ? DW'(ir_q[7:0]) : DW'($signed(ir_q[7:0]));
            pc_target = pc + disp_ext;
            ir        = ir_q;
            unique case (state)
                // Address stays on PC through DECODE while the read data returns.
                ST_FETCH, ST_DECODE: mem_addr_sel = 1'b1;
                ST_EXEC: begin
                    mux_a_sel = rd;
                    mux_b_sel = rs;
                    if (is_branch) begin
                        pc_en = 1'b1;
                        pc_ld = take;
                    end else if (is_mem) begin
                        if (ext == EXT_LOAD) begin
                            mux_a_sel = rs;
                        end else if (ext == EXT_STOR) begin
                            mux_a_sel = rs;
                            mux_b_sel = rd;
                            mem_we    = 1'b1;
                            pc_en     = 1'b1;
                        end else if (ext == EXT_JCOND) begin
                            mux_a_sel  = rs;
                            pc_en      = 1'b1;
                            pc_ld      = take;
                            pc_tgt_sel = 1'b1;
                        end else begin
                            pc_en = 1'b1;  // undefined memory sub-op executes as NOP
                        end
                    end else begin
                        imm_sel = (op != OP_RTYPE);
                        reg_en  = is_cmp ? 16'h0000 : rd_onehot;
                        flag_en = 1'b1;
                        pc_en   = 1'b1;
                    end
                end
                ST_LD_WB: begin
                    // Keep the load address selected while its data is written back.
                    mux_a_sel = rs;
                    wb_sel    = 1'b1;
                    reg_en    = rd_onehot;
                    pc_en     = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] mem_rdata;
    logic [4:0]  flags;
    logic [9:0]  pc;
    logic [7:0]  alu_op;
    logic [15:0] imm;
    logic        imm_sel;
    logic [3:0]  mux_a_sel, mux_b_sel;
    logic [15:0] reg_en;
    logic        wb_sel, flag_en, mem_addr_sel, mem_we, pc_en, pc_ld, pc_tgt_sel;
    logic [9:0]  pc_target;
    logic [15:0] ir;
    logic        halted;

    int vectors;
    int miscompares;

    // Control bundle: {mem_addr_sel, mem_we, pc_en, pc_ld, pc_tgt_sel, flag_en, wb_sel, imm_sel, halted}
    logic [8:0] ctl;
    assign ctl = {mem_addr_sel, mem_we, pc_en, pc_ld, pc_tgt_sel, flag_en, wb_sel, imm_sel, halted};

    instr_sequencer #(.PC_W(10), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_rdata    (mem_rdata),
        .flags        (flags),
        .pc           (pc),
        .alu_op       (alu_op),
        .imm          (imm),
        .imm_sel      (imm_sel),
        .mux_a_sel    (mux_a_sel),
        .mux_b_sel    (mux_b_sel),
        .reg_en       (reg_en),
        .wb_sel       (wb_sel),
        .flag_en      (flag_en),
        .mem_addr_sel (mem_addr_sel),
        .mem_we       (mem_we),
        .pc_en        (pc_en),
        .pc_ld        (pc_ld),
        .pc_tgt_sel   (pc_tgt_sel),
        .pc_target    (pc_target),
        .ir           (ir),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // From FETCH: present the word and advance through DECODE into EXEC.
    task automatic issue(input logic [15:0] w);
        mem_rdata = w;
        step();
        step();
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_rdata = 16'h0152; flags = 5'b01000; pc = 10'h005;
        step(); step();
        if (ctl !== 9'h000) begin miscompares++; $display("FAIL rst_ctl: got %h want %h", ctl, 9'h000); end vectors++;
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL rst_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
        if (ir !== 16'h0000) begin miscompares++; $display("FAIL rst_ir: got %h want %h", ir, 16'h0000); end vectors++;
        if (pc_target !== 10'h000) begin miscompares++; $display("FAIL rst_pc_target: got %h want %h", pc_target, 10'h000); end vectors++;
        reset = 1'b0; pc = 10'h000;
        #1;
        if (ctl !== 9'h100) begin miscompares++; $display("FAIL rst_fetch_ctl: got %h want %h", ctl, 9'h100); end vectors++;
    endtask

    task automatic test_alu;
        pc = 10'h000; flags = 5'b00000;
        mem_rdata = 16'h0152;
        step();
        if (ctl !== 9'h100) begin miscompares++; $display("FAIL add_decode_ctl: got %h want %h", ctl, 9'h100); end vectors++;
        step();
        if (alu_op !== 8'h05) begin miscompares++; $display("FAIL add_alu_op: got %h want %h", alu_op, 8'h05); end vectors++;
        if (mux_a_sel !== 4'd1) begin miscompares++; $display("FAIL add_mux_a: got %h want %h", mux_a_sel, 4'd1); end vectors++;
        if (mux_b_sel !== 4'd2) begin miscompares++; $display("FAIL add_mux_b: got %h want %h", mux_b_sel, 4'd2); end vectors++;
        if (reg_en !== 16'h0002) begin miscompares++; $display("FAIL add_reg_en: got %h want %h", reg_en, 16'h0002); end vectors++;
        if (ctl !== 9'h048) begin miscompares++; $display("FAIL add_ctl: got %h want %h", ctl, 9'h048); end vectors++;
        if (ir !== 16'h0152) begin miscompares++; $display("FAIL add_ir: got %h want %h", ir, 16'h0152); end vectors++;
        pc = 10'h001;
        step();
        if (ctl !== 9'h100) begin miscompares++; $display("FAIL add_next_fetch: got %h want %h", ctl, 9'h100); end vectors++;
    endtask

    task automatic test_immediate;
        issue(16'h52FD);  // ADDI R2, -3
        if (imm !== 16'hFFFD) begin miscompares++; $display("FAIL addi_imm: got %h want %h", imm, 16'hFFFD); end vectors++;
        if (alu_op !== 8'h5F) begin miscompares++; $display("FAIL addi_alu_op: got %h want %h", alu_op, 8'h5F); end vectors++;
        if (reg_en !== 16'h0004) begin miscompares++; $display("FAIL addi_reg_en: got %h want %h", reg_en, 16'h0004); end vectors++;
        if (ctl !== 9'h04A) begin miscompares++; $display("FAIL addi_ctl: got %h want %h", ctl, 9'h04A); end vectors++;
        step();
        issue(16'h1380);  // ANDI R3, 0x80 (zero-extended)
        if (imm !== 16'h0080) begin miscompares++; $display("FAIL andi_imm: got %h want %h", imm, 16'h0080); end vectors++;
        if (reg_en !== 16'h0008) begin miscompares++; $display("FAIL andi_reg_en: got %h want %h", reg_en, 16'h0008); end vectors++;
        step();
        issue(16'h01B2);  // CMP R1, R2
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL cmp_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
        if (ctl !== 9'h048) begin miscompares++; $display("FAIL cmp_ctl: got %h want %h", ctl, 9'h048); end vectors++;
        step();
        issue(16'hB3FF);  // CMPI R3, -1
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL cmpi_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
        if (ctl !== 9'h04A) begin miscompares++; $display("FAIL cmpi_ctl: got %h want %h", ctl, 9'h04A); end vectors++;
        if (imm !== 16'hFFFF) begin miscompares++; $display("FAIL cmpi_imm: got %h want %h", imm, 16'hFFFF); end vectors++;
        step();
    endtask

    task automatic test_load;
        issue(16'h4304);  // LOAD R3, [R4]
        if (ctl !== 9'h000) begin miscompares++; $display("FAIL ld_exec_ctl: got %h want %h", ctl, 9'h000); end vectors++;
        if (mux_a_sel !== 4'd4) begin miscompares++; $display("FAIL ld_mux_a: got %h want %h", mux_a_sel, 4'd4); end vectors++;
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL ld_exec_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
        step();
        if (ctl !== 9'h044) begin miscompares++; $display("FAIL ld_wb_ctl: got %h want %h", ctl, 9'h044); end vectors++;
        if (reg_en !== 16'h0008) begin miscompares++; $display("FAIL ld_wb_reg_en: got %h want %h", reg_en, 16'h0008); end vectors++;
        step();
        if (ctl !== 9'h100) begin miscompares++; $display("FAIL ld_next_fetch: got %h want %h", ctl, 9'h100); end vectors++;
    endtask

    task automatic test_store;
        issue(16'h4546);  // STOR R5, [R6]
        if (ctl !== 9'h0C0) begin miscompares++; $display("FAIL st_ctl: got %h want %h", ctl, 9'h0C0); end vectors++;
        if (mux_a_sel !== 4'd6) begin miscompares++; $display("FAIL st_mux_a: got %h want %h", mux_a_sel, 4'd6); end vectors++;
        if (mux_b_sel !== 4'd5) begin miscompares++; $display("FAIL st_mux_b: got %h want %h", mux_b_sel, 4'd5); end vectors++;
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL st_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
        step();
        if (ctl !== 9'h100) begin miscompares++; $display("FAIL st_next_fetch: got %h want %h", ctl, 9'h100); end vectors++;
    endtask

    task automatic test_branch;
        pc = 10'h001; flags = 5'b01000;  // Z=1
        issue(16'hC0FE);  // BEQ -2
        if (ctl !== 9'h060) begin miscompares++; $display("FAIL beq_taken_ctl: got %h want %h", ctl, 9'h060); end vectors++;
        if (pc_target !== 10'h3FF) begin miscompares++; $display("FAIL beq_target: got %h want %h", pc_target, 10'h3FF); end vectors++;
        step();
        flags = 5'b00000;
        issue(16'hC0FE);
        if (ctl !== 9'h040) begin miscompares++; $display("FAIL beq_not_taken_ctl: got %h want %h", ctl, 9'h040); end vectors++;
        if (pc_target !== 10'h3FF) begin miscompares++; $display("FAIL beq_nt_target: got %h want %h", pc_target, 10'h3FF); end vectors++;
        step();
        pc = 10'h3FF;
        issue(16'hCE01);  // BUC +1 wraps to 0
        if (ctl !== 9'h060) begin miscompares++; $display("FAIL buc_ctl: got %h want %h", ctl, 9'h060); end vectors++;
        if (pc_target !== 10'h000) begin miscompares++; $display("FAIL buc_wrap_target: got %h want %h", pc_target, 10'h000); end vectors++;
        step();
        issue(16'hCF01);  // cond 1111 never taken
        if (ctl !== 9'h040) begin miscompares++; $display("FAIL bnever_ctl: got %h want %h", ctl, 9'h040); end vectors++;
        step();
        pc = 10'h002; flags = 5'b00000;
        issue(16'hCC05);  // BLT +5, !N & !Z
        if (ctl !== 9'h060) begin miscompares++; $display("FAIL blt_taken_ctl: got %h want %h", ctl, 9'h060); end vectors++;
        if (pc_target !== 10'h007) begin miscompares++; $display("FAIL blt_target: got %h want %h", pc_target, 10'h007); end vectors++;
        step();
        flags = 5'b10000;  // N=1
        issue(16'hCC05);
        if (ctl !== 9'h040) begin miscompares++; $display("FAIL blt_not_taken_ctl: got %h want %h", ctl, 9'h040); end vectors++;
        step();
    endtask

    task automatic test_jump;
        flags = 5'b00000;
        issue(16'h4EC7);  // JUC R7
        if (ctl !== 9'h070) begin miscompares++; $display("FAIL juc_ctl: got %h want %h", ctl, 9'h070); end vectors++;
        if (mux_a_sel !== 4'd7) begin miscompares++; $display("FAIL juc_mux_a: got %h want %h", mux_a_sel, 4'd7); end vectors++;
        step();
        issue(16'h4FC7);  // never-taken jump
        if (ctl !== 9'h050) begin miscompares++; $display("FAIL jnever_ctl: got %h want %h", ctl, 9'h050); end vectors++;
        step();
        issue(16'h4123);  // undefined memory sub-op: NOP
        if (ctl !== 9'h040) begin miscompares++; $display("FAIL nop_ctl: got %h want %h", ctl, 9'h040); end vectors++;
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL nop_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
        step();
    endtask

    task automatic test_reset_mid;
        issue(16'h4304);
        step();  // now in LD_WB
        reset = 1'b1;
        #1;
        if (ctl !== 9'h000) begin miscompares++; $display("FAIL midrst_ctl: got %h want %h", ctl, 9'h000); end vectors++;
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL midrst_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
        step();
        reset = 1'b0;
        #1;
        if (ctl !== 9'h100) begin miscompares++; $display("FAIL midrst_fetch: got %h want %h", ctl, 9'h100); end vectors++;
        if (ir !== 16'h0000) begin miscompares++; $display("FAIL midrst_ir: got %h want %h", ir, 16'h0000); end vectors++;
        if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL midrst_fetch_reg_en: got %h want %h", reg_en, 16'h0000); end vectors++;
    endtask

    task automatic test_halt;
        issue(16'hFFFF);
        if (ctl !== 9'h001) begin miscompares++; $display("FAIL halt_ctl: got %h want %h", ctl, 9'h001); end vectors++;
        if (ir !== 16'hFFFF) begin miscompares++; $display("FAIL halt_ir: got %h want %h", ir, 16'hFFFF); end vectors++;
        mem_rdata = 16'h0152;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ctl !== 9'h001) begin miscompares++; $display("FAIL halt_hold_ctl[%0d]: got %h want %h", i, ctl, 9'h001); end vectors++;
            if (reg_en !== 16'h0000) begin miscompares++; $display("FAIL halt_hold_reg_en[%0d]: got %h want %h", i, reg_en, 16'h0000); end vectors++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        if (ctl !== 9'h100) begin miscompares++; $display("FAIL halt_exit_fetch: got %h want %h", ctl, 9'h100); end vectors++;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        mem_rdata   = 16'h0000;
        flags       = 5'b00000;
        pc          = 10'h000;
        test_reset();
        test_alu();
        test_immediate();
        test_load();
        test_store();
        test_branch();
        test_jump();
        test_reset_mid();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
